// File: rtl/change_game_core_if.sv
// Board-side bundle for change_game_core: switch/pushbutton inputs, game outputs.
// The timeout pulse exists only when CHANGE_TIMEOUT_EN is defined.
interface change_game_core_if #(
    parameter int unsigned NUM_COINS = 4,
    parameter int unsigned TARGET_W  = 7,
    parameter int unsigned LED_W     = 10
);
    logic                   pb;
    logic [NUM_COINS-1:0]   sw;
    logic                   tick;
    logic [TARGET_W-1:0]    target;
    logic [4*NUM_COINS-1:0] coin_cnt;
    logic [11:0]            sum;
    logic                   match;
    logic                   win;
    logic [LED_W-1:0]       led;
`ifdef CHANGE_TIMEOUT_EN
    logic                   timeout;
`endif

    modport master (
        output pb, sw,
        input  tick, target, coin_cnt, sum, match, win, led
`ifdef CHANGE_TIMEOUT_EN
        , input timeout
`endif
    );

    modport slave (
        input  pb, sw,
        output tick, target, coin_cnt, sum, match, win, led
`ifdef CHANGE_TIMEOUT_EN
        , output timeout
`endif
    );
endinterface

// File: rtl/change_game_core.sv
// Coin-change game engine: LFSR target, per-tick coin add, LED score bar.
// Optional round timeout enabled by defining CHANGE_TIMEOUT_EN.
module change_game_core #(
    parameter int unsigned               CLK_HZ     = 50_000_000,
    parameter int unsigned               TICK_HZ    = 6,
    parameter int unsigned               NUM_COINS  = 4,
    parameter logic [8*NUM_COINS-1:0]    COIN_VALS  = {8'd50, 8'd10, 8'd5, 8'd1},
    parameter logic [4*NUM_COINS-1:0]    COIN_MAX   = {4'd1, 4'd4, 4'd1, 4'd4},
    parameter int unsigned               TARGET_W   = 7,
    parameter int unsigned               TARGET_MAX = 99,
    parameter int unsigned               LED_W      = 10
`ifdef CHANGE_TIMEOUT_EN
    , parameter int unsigned             ROUND_TICKS = 20
`endif
) (
    input  logic              clk,
    input  logic              rst,
    change_game_core_if.slave bus
);
    localparam int unsigned DIV_TERM = CLK_HZ / TICK_HZ - 1;
    localparam int unsigned DIV_W    = (DIV_TERM > 0) ? $clog2(DIV_TERM + 1) : 1;
    localparam int unsigned SCORE_W  = $clog2(LED_W + 1);

    function automatic int unsigned max_sum();
        int unsigned acc;
        acc = 0;
        for (int unsigned i = 0; i < NUM_COINS; i++)
            acc = acc + 32'(COIN_VALS[8*i +: 8]) * 32'(COIN_MAX[4*i +: 4]);
        return acc;
    endfunction

    if (max_sum() > 4095 || NUM_COINS < 1 || NUM_COINS > 8 ||
        TARGET_MAX < 1 || TARGET_MAX >= (1 << TARGET_W)) begin : g_bad_cfg
        $error("change_game_core: invalid parameter set");
    end

    typedef enum logic [1:0] {S_GEN, S_PLAY, S_WIN} state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q;
    logic [15:0]            lfsr_q;
    logic [TARGET_W-1:0]    target_q, target_d;
    logic [4*NUM_COINS-1:0] cnt_q, cnt_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic                   win_q, win_d;
    logic                   tick_c, match_c;
    logic [11:0]            sum_c;
`ifdef CHANGE_TIMEOUT_EN
    localparam int unsigned RT_W = $clog2(ROUND_TICKS + 1);
    logic [RT_W-1:0]        rcnt_q, rcnt_d;
    logic                   timeout_q, timeout_d;
`endif

    assign tick_c = (div_q == DIV_W'(DIV_TERM));

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++)
            sum_c = sum_c + 12'(cnt_q[4*i +: 4]) * 12'(COIN_VALS[8*i +: 8]);
    end

    assign match_c = (state_q == S_PLAY) && (sum_c == 12'(target_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_GEN;
            div_q    <= '0;
            lfsr_q   <= 16'hACE1;
            target_q <= '0;
            cnt_q    <= '0;
            score_q  <= '0;
            win_q    <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
            rcnt_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= tick_c ? '0 : div_q + 1'b1;
            // taps 16,14,13,11 -> bits 15,13,12,10
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            target_q <= target_d;
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            win_q    <= win_d;
`ifdef CHANGE_TIMEOUT_EN
            rcnt_q    <= rcnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        int unsigned hi;
        logic        any;
        logic        do_add;
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        score_d  = score_q;
        win_d    = 1'b0;
        do_add   = 1'b0;
        hi       = 0;
        any      = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
        rcnt_d    = rcnt_q;
        timeout_d = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (bus.sw[i]) begin
                hi  = i;
                any = 1'b1;
            end
        end

        case (state_q)
            S_GEN: begin
                target_d = TARGET_W'((32'(lfsr_q) % TARGET_MAX) + 32'd1);
                cnt_d    = '0;
                state_d  = S_PLAY;
`ifdef CHANGE_TIMEOUT_EN
                rcnt_d   = '0;
`endif
            end
            S_PLAY: begin
                if (tick_c) begin
                    if (match_c) begin
                        score_d = (score_q == SCORE_W'(LED_W)) ? '0 : score_q + 1'b1;
                        win_d   = 1'b1;
                        state_d = S_WIN;
`ifdef CHANGE_TIMEOUT_EN
                    end else if (rcnt_q == RT_W'(ROUND_TICKS - 1)) begin
                        timeout_d = 1'b1;
                        score_d   = (score_q == '0) ? '0 : score_q - 1'b1;
                        state_d   = S_GEN;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                        do_add = any;
`else
                    end else begin
                        do_add = any;
`endif
                    end
                end
            end
            S_WIN: begin
                if (tick_c) state_d = S_GEN;
            end
            default: state_d = S_GEN;
        endcase

        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (do_add && i == hi)
                cnt_d[4*i +: 4] = (cnt_q[4*i +: 4] == COIN_MAX[4*i +: 4]) ? 4'd0
                                                                        : cnt_q[4*i +: 4] + 4'd1;
        end

        // pushbutton clear overrides any increment in the same cycle
        if (!bus.pb) cnt_d = '0;
    end

    assign bus.tick     = tick_c;
    assign bus.target   = target_q;
    assign bus.coin_cnt = cnt_q;
    assign bus.sum      = sum_c;
    assign bus.match    = match_c;
    assign bus.win      = win_q;
    assign bus.led      = ~({LED_W{1'b1}} << score_q);
`ifdef CHANGE_TIMEOUT_EN
    assign bus.timeout  = timeout_q;
`endif
endmodule
